// File: rtl/cpu_pkg.sv
// Shared CPU types: op classes from decode and the ID/EX controller state encoding.
package cpu_pkg;

    localparam int unsigned REG_AW_DEFAULT = 4;

    typedef enum logic [2:0] {
        OpAlu    = 3'd0,
        OpLoad   = 3'd1,
        OpStore  = 3'd2,
        OpMul    = 3'd3,
        OpBranch = 3'd4,
        OpHalt   = 3'd5
    } op_class_t;

    typedef enum logic [2:0] {
        StIdle,
        StMem,
        StMul,
        StBr,
        StHalted
    } id_ex_state_t;

endpackage

// File: rtl/id_ex_perf_cnt.sv
// Issue and stall performance counters for the ID/EX controller.
// Issue count wraps; stall count saturates so long stalls never read as small.
module id_ex_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic        stall,
    output logic [31:0] perf_issue_cnt,
    output logic [15:0] perf_stall_cnt
);

    // Count issued instructions and stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (stall && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/id_ex_controller.sv
// Decode/execute sequencing controller: single-issue, in-order issue decision,
// stalls for MEM/MUL/BR and load-use hazards, branch flush and sticky halt.
// Optional feature macro: ID_EX_PERF_EN adds issue/stall performance counters.
module id_ex_controller #(
    parameter int unsigned REG_AW  = cpu_pkg::REG_AW_DEFAULT,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [2:0]        id_class,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              mem_ready,
    input  logic              br_taken,
    output logic              id_stall,
    output logic              ex_issue,
    output logic              mul_start,
    output logic              flush,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       perf_issue_cnt,
    output logic [15:0]       perf_stall_cnt,
`endif
    output logic              halted
);

    import cpu_pkg::*;

    localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 1);

    id_ex_state_t      state_q;
    logic [3:0]        mul_cnt_q;
    logic              ld_pend_q;
    logic [REG_AW-1:0] ld_rd_q;
    logic              cap_load_q;
    logic [REG_AW-1:0] cap_rd_q;
    op_class_t         cls;
    logic              hazard;

    // Unknown class encodings behave as ALU.
    always_comb begin
        cls = OpAlu;
        case (id_class)
            3'd1:    cls = OpLoad;
            3'd2:    cls = OpStore;
            3'd3:    cls = OpMul;
            3'd4:    cls = OpBranch;
            3'd5:    cls = OpHalt;
            default: cls = OpAlu;
        endcase
    end

    // Issue decision and combinational handshakes; all forced low while rst is held.
    always_comb begin
        // ld_rd_q is never r0, so a match here already excludes r0.
        hazard    = ld_pend_q && ((id_uses_rs1 && (id_rs1 == ld_rd_q)) ||
                                  (id_uses_rs2 && (id_rs2 == ld_rd_q)));
        ex_issue  = !rst && (state_q == StIdle) && id_valid && !hazard;
        id_stall  = !rst && id_valid && !ex_issue;
        mul_start = ex_issue && (cls == OpMul);
        flush     = !rst && (state_q == StBr) && br_taken;
    end

    // Sequencing FSM with load-use tracking and registered halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mul_cnt_q  <= '0;
            ld_pend_q  <= 1'b0;
            ld_rd_q    <= '0;
            cap_load_q <= 1'b0;
            cap_rd_q   <= '0;
            halted     <= 1'b0;
        end else begin
            // Load-use window is a single cycle.
            ld_pend_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ex_issue) begin
                        cap_load_q <= (cls == OpLoad) && id_rd_we && (id_rd != '0);
                        cap_rd_q   <= id_rd;
                        case (cls)
                            OpLoad, OpStore: state_q <= StMem;
                            OpMul: begin
                                state_q   <= StMul;
                                mul_cnt_q <= MulCntInit;
                            end
                            OpBranch: state_q <= StBr;
                            OpHalt: begin
                                state_q <= StHalted;
                                halted  <= 1'b1;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        state_q <= StIdle;
                        if (cap_load_q) begin
                            ld_pend_q <= 1'b1;
                            ld_rd_q   <= cap_rd_q;
                        end
                    end
                end
                StMul: begin
                    mul_cnt_q <= mul_cnt_q - 4'd1;
                    if (mul_cnt_q <= 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                StBr:     state_q <= StIdle;
                StHalted: state_q <= StHalted;
                default:  state_q <= StIdle;
            endcase
        end
    end

`ifdef ID_EX_PERF_EN
    id_ex_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .issue          (ex_issue),
        .stall          (id_stall),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_id_ex_controller.sv
// Scoreboard bench for id_ex_controller: each driven cycle pushes the expected
// {ex_issue, id_stall, mul_start, flush, halted} and pops it when outputs settle.
module tb_id_ex_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_class;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_rd_we;
    logic       mem_ready, br_taken;
    logic       id_stall, ex_issue, mul_start, flush, halted;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    id_ex_controller #(
        .REG_AW  (4),
        .MUL_LAT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_class    (id_class),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .mem_ready   (mem_ready),
        .br_taken    (br_taken),
        .id_stall    (id_stall),
        .ex_issue    (ex_issue),
        .mul_start   (mul_start),
        .flush       (flush),
`ifdef ID_EX_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .halted      (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One cycle: drive after the falling edge, compare 1ns before the rising edge.
    task automatic cyc(input string tag, input logic r, input logic v, input logic [2:0] c,
                       input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                       input logic u2, input logic [3:0] rd, input logic we,
                       input logic mr, input logic bt, input logic [4:0] exp);
        logic [4:0] e;
        @(negedge clk);
        rst = r; id_valid = v; id_class = c;
        id_rs1 = s1; id_uses_rs1 = u1; id_rs2 = s2; id_uses_rs2 = u2;
        id_rd = rd; id_rd_we = we; mem_ready = mr; br_taken = bt;
        exp_q.push_back(exp);
        #4;
        e = exp_q.pop_front();
        check_eq({tag, ".issue"},  {31'd0, ex_issue},  {31'd0, e[4]});
        check_eq({tag, ".stall"},  {31'd0, id_stall},  {31'd0, e[3]});
        check_eq({tag, ".mul"},    {31'd0, mul_start}, {31'd0, e[2]});
        check_eq({tag, ".flush"},  {31'd0, flush},     {31'd0, e[1]});
        check_eq({tag, ".halted"}, {31'd0, halted},    {31'd0, e[0]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_class = 3'd0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd_we = 1'b0;
        mem_ready = 1'b0; br_taken = 1'b0;
        repeat (2) @(posedge clk);

        // exp = {issue, stall, mul_start, flush, halted}
        cyc("rst_valid", 1, 1, 3'd0, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0, 5'b00000);

        for (int i = 0; i < 4; i++)
            cyc("alu", 0, 1, 3'd0, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0, 5'b10000);

        // MUL at t, ALU waits until t+3
        cyc("mul_t0", 0, 1, 3'd3, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 5'b10100);
        cyc("mul_t1", 0, 1, 3'd0, 4'd4, 1, 4'd3, 1, 4'd6, 1, 0, 0, 5'b01000);
        cyc("mul_t2", 0, 1, 3'd0, 4'd4, 1, 4'd3, 1, 4'd6, 1, 0, 0, 5'b01000);
        cyc("mul_t3", 0, 1, 3'd0, 4'd4, 1, 4'd3, 1, 4'd6, 1, 0, 0, 5'b10000);

        // LOAD r5, mem_ready at t+2, dependent ALU issues t+4
        cyc("ld5_t0", 0, 1, 3'd1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0, 0, 5'b10000);
        cyc("ld5_t1", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b01000);
        cyc("ld5_t2", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 1, 0, 5'b01000);
        cyc("ld5_t3", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b01000);
        cyc("ld5_t4", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b10000);

        // LOAD r0: no hazard afterwards
        cyc("ld0_t0", 0, 1, 3'd1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 0, 0, 5'b10000);
        cyc("ld0_t1", 0, 1, 3'd0, 4'd0, 1, 4'd0, 1, 4'd1, 1, 0, 0, 5'b01000);
        cyc("ld0_t2", 0, 1, 3'd0, 4'd0, 1, 4'd0, 1, 4'd1, 1, 1, 0, 5'b01000);
        cyc("ld0_t3", 0, 1, 3'd0, 4'd0, 1, 4'd0, 1, 4'd1, 1, 0, 0, 5'b10000);

        // LOAD r5, matching rs fields unused: no hazard
        cyc("ldu_t0", 0, 1, 3'd1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0, 0, 5'b10000);
        cyc("ldu_t1", 0, 1, 3'd0, 4'd5, 0, 4'd5, 0, 4'd1, 1, 0, 0, 5'b01000);
        cyc("ldu_t2", 0, 1, 3'd0, 4'd5, 0, 4'd5, 0, 4'd1, 1, 1, 0, 5'b01000);
        cyc("ldu_t3", 0, 1, 3'd0, 4'd5, 0, 4'd5, 0, 4'd1, 1, 0, 0, 5'b10000);

        // LOAD r7, mem_ready at t+1, rs2 hazard
        cyc("ld7_t0", 0, 1, 3'd1, 4'd1, 1, 4'd0, 0, 4'd7, 1, 0, 0, 5'b10000);
        cyc("ld7_t1", 0, 1, 3'd0, 4'd2, 1, 4'd7, 1, 4'd3, 1, 1, 0, 5'b01000);
        cyc("ld7_t2", 0, 1, 3'd0, 4'd2, 1, 4'd7, 1, 4'd3, 1, 0, 0, 5'b01000);
        cyc("ld7_t3", 0, 1, 3'd0, 4'd2, 1, 4'd7, 1, 4'd3, 1, 0, 0, 5'b10000);

        // STORE never creates a load-use hazard
        cyc("st_t0", 0, 1, 3'd2, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 5'b10000);
        cyc("st_t1", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 1, 0, 5'b01000);
        cyc("st_t2", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b10000);

        // BRANCH taken: flush only at t+1; br_taken/mem_ready ignored in IDLE
        cyc("brt_t0", 0, 1, 3'd4, 4'd1, 1, 4'd2, 1, 4'd0, 0, 0, 0, 5'b10000);
        cyc("brt_t1", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 1, 5'b01010);
        cyc("brt_t2", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 1, 1, 5'b10000);

        // BRANCH not taken
        cyc("brn_t0", 0, 1, 3'd4, 4'd1, 1, 4'd2, 1, 4'd0, 0, 0, 0, 5'b10000);
        cyc("brn_t1", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b01000);
        cyc("brn_t2", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b10000);

        // Class 7 behaves as ALU
        cyc("cls7", 0, 1, 3'd7, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b10000);
        cyc("cls7b", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b10000);

        // rst during MEM wait: late mem_ready ignored, no load-use stall
        cyc("rmem_t0", 0, 1, 3'd1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0, 0, 5'b10000);
        cyc("rmem_t1", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b01000);
        cyc("rmem_t2", 1, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b00000);
        cyc("rmem_t3", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 1, 0, 5'b10000);
`ifdef ID_EX_PERF_EN
        check_eq("perf_issue_after_rst", perf_issue_cnt, 32'd0);
        check_eq("perf_stall_after_rst", {16'd0, perf_stall_cnt}, 32'd0);
`endif
        cyc("rmem_t4", 0, 1, 3'd0, 4'd5, 1, 4'd0, 0, 4'd1, 1, 0, 0, 5'b10000);

        // HALT: sticky until rst
        cyc("halt_t0", 0, 1, 3'd5, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b10000);
        cyc("halt_t1", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 1, 1, 5'b01001);
        cyc("halt_t2", 0, 0, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b00001);
        cyc("halt_t3", 0, 1, 3'd3, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b01001);
        cyc("halt_rst", 1, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b00001);
        cyc("halt_rel", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b10000);
        cyc("halt_rel2", 0, 1, 3'd0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 5'b10000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
